// File: rtl/gtp_rx.sv
// Receive-side framer for the GTP link: splits data frames into payload RAM writes,
// checks the CRC-32 trailer and flags trigger frames and framing errors.
module gtp_rx #(
   parameter logic [31:0] HEAD_WORD     = 32'h0000FFBC,
   parameter logic [31:0] END_WORD      = 32'h0000FFBD,
   parameter logic [31:0] TRIG_WORD     = 32'h0000FFBA,
   parameter logic [31:0] TRIG_END_WORD = 32'h0000FFBB
) (
   input  logic        log_clk,
   input  logic        log_rst_n,
   input  logic [31:0] m_axi_rx_tdata,
   input  logic        m_axi_rx_tvalid,
   input  logic        m_axi_rx_tlast,
   output logic [7:0]  rx_packet_addra,
   output logic [31:0] rx_packet_dina,
   output logic        rx_packet_wea,
   output logic [31:0] rx_packet_gtxid,
   output logic [31:0] rx_packet_head,
   output logic        rx_packet_done,
   output logic        rx_crc_err,
   output logic        rx_frame_err,
   output logic        rx_trigger
);

   localparam int                 DATA_W   = 32;
   localparam logic [DATA_W-1:0] CRC_POLY = 32'h04C11DB7;
   localparam logic [DATA_W-1:0] CRC_INIT = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      S_IDLE, S_GTXID, S_LENGTH, S_DATA, S_CHECK, S_END, S_TRIG_END, S_DROP
   } state_t;

   state_t state, state_nx;

   logic [DATA_W-1:0] crc;
   logic [DATA_W-1:0] gtxid_cap;
   logic [DATA_W-1:0] head_cap;
   logic [7:0]        len_n;
   logic [7:0]        base_addr;
   logic [7:0]        word_cnt;
   logic              crc_ok;

   logic wr, ld_gtxid, ld_len, ld_chk;
   logic ev_done, ev_crc_err, ev_frame_err, ev_trig;

   logic              wea_p1;
   logic [7:0]        addra_p1;
   logic [DATA_W-1:0] dina_p1;
   logic              done_p1, crc_err_p1, frame_err_p1, trig_p1;
   logic [DATA_W-1:0] gtxid_p1, head_p1;

   // 32-bit parallel CRC-32 step, data consumed MSB first
   function automatic logic [DATA_W-1:0] crc32_d32(input logic [DATA_W-1:0] d,
                                                   input logic [DATA_W-1:0] c);
      logic [DATA_W-1:0] r;
      r = c;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         r = {r[DATA_W-2:0], 1'b0} ^ ((r[DATA_W-1] ^ d[i]) ? CRC_POLY : '0);
      end
      return r;
   endfunction

   always_ff @(posedge log_clk or negedge log_rst_n) begin
      if (!log_rst_n) state <= S_IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      wr           = 1'b0;
      ld_gtxid     = 1'b0;
      ld_len       = 1'b0;
      ld_chk       = 1'b0;
      ev_done      = 1'b0;
      ev_crc_err   = 1'b0;
      ev_frame_err = 1'b0;
      ev_trig      = 1'b0;
      if (m_axi_rx_tvalid) begin
         case (state)
            S_IDLE: begin
               if (m_axi_rx_tdata == HEAD_WORD || m_axi_rx_tdata == TRIG_WORD) begin
                  if (m_axi_rx_tlast) ev_frame_err = 1'b1;
                  else if (m_axi_rx_tdata == HEAD_WORD) state_nx = S_GTXID;
                  else state_nx = S_TRIG_END;
               end else if (!m_axi_rx_tlast) begin
                  state_nx = S_DROP;
               end
            end
            S_GTXID: begin
               if (m_axi_rx_tlast) begin
                  ev_frame_err = 1'b1;
                  state_nx     = S_IDLE;
               end else begin
                  ld_gtxid = 1'b1;
                  state_nx = S_LENGTH;
               end
            end
            S_LENGTH: begin
               if (m_axi_rx_tlast) begin
                  ev_frame_err = 1'b1;
                  state_nx     = S_IDLE;
               end else begin
                  ld_len   = 1'b1;
                  state_nx = (m_axi_rx_tdata[7:0] == 8'd0) ? S_CHECK : S_DATA;
               end
            end
            S_DATA: begin
               // a truncating beat still carries payload and is written
               wr = 1'b1;
               if (m_axi_rx_tlast) begin
                  ev_frame_err = 1'b1;
                  state_nx     = S_IDLE;
               end else if (word_cnt == len_n - 8'd1) begin
                  state_nx = S_CHECK;
               end
            end
            S_CHECK: begin
               if (m_axi_rx_tlast) begin
                  ev_frame_err = 1'b1;
                  state_nx     = S_IDLE;
               end else begin
                  ld_chk   = 1'b1;
                  state_nx = S_END;
               end
            end
            S_END: begin
               if (m_axi_rx_tdata == END_WORD && m_axi_rx_tlast) begin
                  ev_done    = crc_ok;
                  ev_crc_err = !crc_ok;
                  state_nx   = S_IDLE;
               end else begin
                  ev_frame_err = 1'b1;
                  state_nx     = m_axi_rx_tlast ? S_IDLE : S_DROP;
               end
            end
            S_TRIG_END: begin
               if (m_axi_rx_tdata == TRIG_END_WORD && m_axi_rx_tlast) begin
                  ev_trig  = 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  ev_frame_err = 1'b1;
                  state_nx     = m_axi_rx_tlast ? S_IDLE : S_DROP;
               end
            end
            S_DROP: begin
               if (m_axi_rx_tlast) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // frame context: CRC, captured header words, payload counters
   always_ff @(posedge log_clk or negedge log_rst_n) begin
      if (!log_rst_n) begin
         crc       <= CRC_INIT;
         gtxid_cap <= '0;
         head_cap  <= '0;
         len_n     <= '0;
         base_addr <= '0;
         word_cnt  <= '0;
         crc_ok    <= 1'b0;
      end else begin
         if (ld_gtxid) begin
            gtxid_cap <= m_axi_rx_tdata;
            crc       <= crc32_d32(m_axi_rx_tdata, CRC_INIT);
         end
         if (ld_len) begin
            head_cap  <= m_axi_rx_tdata;
            len_n     <= m_axi_rx_tdata[7:0];
            base_addr <= m_axi_rx_tdata[15:8];
            word_cnt  <= '0;
            crc       <= crc32_d32(m_axi_rx_tdata, crc);
         end
         if (wr) begin
            word_cnt <= word_cnt + 8'd1;
            crc      <= crc32_d32(m_axi_rx_tdata, crc);
         end
         if (ld_chk) crc_ok <= (m_axi_rx_tdata == crc);
      end
   end

   // registered RAM port and status pulses, one cycle after the beat
   always_ff @(posedge log_clk or negedge log_rst_n) begin
      if (!log_rst_n) begin
         wea_p1       <= 1'b0;
         addra_p1     <= '0;
         dina_p1      <= '0;
         done_p1      <= 1'b0;
         crc_err_p1   <= 1'b0;
         frame_err_p1 <= 1'b0;
         trig_p1      <= 1'b0;
         gtxid_p1     <= '0;
         head_p1      <= '0;
      end else begin
         wea_p1       <= wr;
         done_p1      <= ev_done;
         crc_err_p1   <= ev_crc_err;
         frame_err_p1 <= ev_frame_err;
         trig_p1      <= ev_trig;
         if (wr) begin
            addra_p1 <= base_addr + word_cnt;
            dina_p1  <= m_axi_rx_tdata;
         end
         if (ev_done) begin
            gtxid_p1 <= gtxid_cap;
            head_p1  <= head_cap;
         end
      end
   end

   assign rx_packet_wea   = wea_p1;
   assign rx_packet_addra = addra_p1;
   assign rx_packet_dina  = dina_p1;
   assign rx_packet_done  = done_p1;
   assign rx_crc_err      = crc_err_p1;
   assign rx_frame_err    = frame_err_p1;
   assign rx_trigger      = trig_p1;
   assign rx_packet_gtxid = gtxid_p1;
   assign rx_packet_head  = head_p1;

endmodule

// File: doc/gtp_rx.md
GTP_RX -- requirements
Module: gtp_rx

Interface
REQ-001 SHALL have parameter HEAD_WORD, default 32'h0000FFBC, data-frame start marker.
REQ-002 SHALL have parameter END_WORD, default 32'h0000FFBD, data-frame end marker.
REQ-003 SHALL have parameter TRIG_WORD, default 32'h0000FFBA, trigger-frame start marker.
REQ-004 SHALL have parameter TRIG_END_WORD, default 32'h0000FFBB, trigger-frame end marker.
REQ-005 SHALL have port log_clk, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port log_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port m_axi_rx_tdata, input, 32, received stream word.
REQ-008 SHALL have port m_axi_rx_tvalid, input, 1, beat valid; no back-pressure, every valid beat is consumed.
REQ-009 SHALL have port m_axi_rx_tlast, input, 1, last beat of frame.
REQ-010 SHALL have port rx_packet_addra, output, 8, payload RAM write address.
REQ-011 SHALL have port rx_packet_dina, output, 32, payload RAM write data.
REQ-012 SHALL have port rx_packet_wea, output, 1, payload RAM write strobe.
REQ-013 SHALL have port rx_packet_gtxid, output, 32, GTX ID of the last good frame.
REQ-014 SHALL have port rx_packet_head, output, 32, length word of the last good frame.
REQ-015 SHALL have port rx_packet_done, output, 1, one-cycle pulse on a good data frame.
REQ-016 SHALL have port rx_crc_err, output, 1, one-cycle pulse on a CRC mismatch.
REQ-017 SHALL have port rx_frame_err, output, 1, one-cycle pulse on a framing error.
REQ-018 SHALL have port rx_trigger, output, 1, one-cycle pulse on a complete trigger frame.

Function
REQ-019 Beat = cycle with m_axi_rx_tvalid=1; without a beat, state, CRC and counters SHALL hold.
REQ-020 States SHALL be IDLE, GTXID, LENGTH, DATA, CHECK, END, TRIG_END and DROP.
REQ-021 IDLE: HEAD_WORD beat -> GTXID; TRIG_WORD beat -> TRIG_END; any other beat ignored, with tlast=0 -> DROP.
REQ-022 GTXID beat -> LENGTH: captures gtxid, CRC <= nextCRC32_D32(tdata, 32'hFFFFFFFF).
REQ-023 LENGTH beat -> captures length word, CRC updated; N=tdata[7:0], base address A=tdata[15:8], word counter cleared; N=0 -> CHECK, else -> DATA.
REQ-024 DATA: each beat writes (addr A+i, data tdata) to RAM and updates CRC; after the N-th beat -> CHECK.
REQ-025 RAM address SHALL wrap modulo 256 (A=8'hFF, i=1 -> 8'h00).
REQ-026 RAM write outputs SHALL be registered: wea/addra/dina valid the cycle after the DATA beat; wea=1 for exactly one cycle per data beat.
REQ-027 CHECK beat -> END; beat compared with the running CRC and the result latched; CHECK beat is not CRC-updated.
REQ-028 CRC SHALL be CRC-32 poly 0x04C11DB7, 32-bit parallel update nextCRC32_D32(data, crc), init 32'hFFFFFFFF, no reflection, no final XOR, covering GTXID, LENGTH and DATA words only.
REQ-029 END beat equal to END_WORD with tlast=1 -> IDLE. Next cycle: rx_packet_done=1 with gtxid/head outputs updated if CRC matched; otherwise rx_crc_err=1 with outputs unchanged.
REQ-030 TRIG_END beat equal to TRIG_END_WORD with tlast=1 -> IDLE; rx_trigger=1 on the next cycle.
REQ-031 tlast=1 on any beat before END/TRIG_END -> rx_frame_err pulse, -> IDLE.
REQ-032 END/TRIG_END beat with the wrong marker and tlast=1 -> rx_frame_err, -> IDLE; wrong marker or tlast=0 without tlast -> rx_frame_err, -> DROP.
REQ-033 DROP SHALL discard beats until a tlast beat, then -> IDLE; no writes occur and no further pulse is issued.
REQ-034 A framing error SHALL suppress rx_packet_done and rx_crc_err for that frame; RAM writes already issued are not retracted.
REQ-035 A new frame SHALL be accepted on the beat immediately following the closing beat (zero gap).
REQ-036 Pulses SHALL be mutually exclusive and one cycle wide.

Reset
REQ-037 log_rst_n=0 SHALL asynchronously force IDLE, CRC=32'hFFFFFFFF, all outputs 0, including mid-frame; after release, only a fresh marker starts a frame.

Verification
REQ-038 HEAD, gtxid 32'h12, length 32'h0000_1003, 3 data words, golden CRC, END+tlast -> wea at 8'h10/11/12, rx_packet_done once, gtxid=32'h12, head=32'h1003.
REQ-039 Same frame with CRC word bit0 flipped -> 3 writes, rx_crc_err once, no done, gtxid/head unchanged.
REQ-040 TRIG_WORD then TRIG_END_WORD+tlast, back-to-back with a data frame -> rx_trigger once, data frame still done.
REQ-041 length 32'h0000_FF02 -> writes at 8'hFF then 8'h00.
REQ-042 tlast on 2nd data word of N=4 -> rx_frame_err, 2 writes, IDLE; next good frame -> done.
REQ-043 log_rst_n low during DATA, valid beats idle on release -> no write, no pulse, CRC=FFFFFFFF; next good frame -> done.
